// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle between the scanner (master) and the keypad/consumer side (slave).
// rows come from the pads; columns drive the pads; keycode/key_valid/key_held feed the calculator FSM.
interface keypad_scanner_if;
   logic [3:0] rows;
   logic [3:0] columns;
   logic [3:0] keycode;
   logic       key_valid;
   logic       key_held;

   modport master (
      input  rows,
      output columns,
      output keycode,
      output key_valid,
      output key_held
   );

   modport slave (
      output rows,
      input  columns,
      input  keycode,
      input  key_valid,
      input  key_held
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotating one-hot column strobe, 2-flop row synchroniser, press/release debounce.
// Keycode strobes DEBOUNCE_CNT clocks after the detecting sample; no backpressure, key_valid is a one-cycle pulse.
module keypad_scanner #(
   parameter int SCAN_DIV     = 4096,
   parameter int DEBOUNCE_CNT = 65536
) (
   input  logic             clk,
   input  logic             reset,
   keypad_scanner_if.master kp
);

   localparam int DW = $clog2(SCAN_DIV) + 1;
   localparam int BW = $clog2(DEBOUNCE_CNT) + 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] DB_DONE    = BW'(DEBOUNCE_CNT);

   typedef enum logic [1:0] {
      SCAN       = 2'd0,
      PRESS_DB   = 2'd1,
      HOLD       = 2'd2,
      RELEASE_DB = 2'd3
   } state_t;

   state_t        state_q,     state_d;
   logic [DW-1:0] dwell_q,     dwell_d;
   logic [BW-1:0] db_q,        db_d;
   logic [3:0]    col_q,       col_d;
   logic [3:0]    row_q,       row_d;
   logic [3:0]    keycode_q,   keycode_d;
   logic          key_valid_q, key_valid_d;
   logic          key_held_q,  key_held_d;
   logic [3:0]    rs_meta_q,   rs_meta_d;
   logic [3:0]    rs_q,        rs_d;

   logic [DW-1:0] dwell_inc;
   logic [BW-1:0] db_inc;
   logic [3:0]    col_rot;

   function automatic logic is_one_hot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
   endfunction

   // Column-major keypad legend: 1 2 3 + / 4 5 6 - / 7 8 9 * / = 0 R /
   function automatic logic [3:0] key_map(input logic [3:0] col, input logic [3:0] row);
      logic [3:0] code;
      code = 4'h0;
      case ({col, row})
         8'b0001_0001: code = 4'h1;
         8'b0001_0010: code = 4'h4;
         8'b0001_0100: code = 4'h7;
         8'b0001_1000: code = 4'hE;
         8'b0010_0001: code = 4'h2;
         8'b0010_0010: code = 4'h5;
         8'b0010_0100: code = 4'h8;
         8'b0010_1000: code = 4'h0;
         8'b0100_0001: code = 4'h3;
         8'b0100_0010: code = 4'h6;
         8'b0100_0100: code = 4'h9;
         8'b0100_1000: code = 4'hF;
         8'b1000_0001: code = 4'hA;
         8'b1000_0010: code = 4'hB;
         8'b1000_0100: code = 4'hC;
         8'b1000_1000: code = 4'hD;
         default:      code = 4'h0;
      endcase
      return code;
   endfunction

   // Both counters saturate rather than wrap.
   assign dwell_inc = (dwell_q == DWELL_LAST) ? dwell_q : dwell_q + DW'(1);
   assign db_inc    = (db_q == DB_DONE) ? db_q : db_q + BW'(1);
   assign col_rot   = {col_q[2:0], col_q[3]};

   always_comb begin
      state_d     = state_q;
      dwell_d     = dwell_q;
      db_d        = db_q;
      col_d       = col_q;
      row_d       = row_q;
      keycode_d   = keycode_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      rs_meta_d   = kp.rows;
      rs_d        = rs_meta_q;

      case (state_q)
         SCAN: begin
            if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               if (is_one_hot(rs_q)) begin
                  row_d   = rs_q;
                  db_d    = '0;
                  state_d = PRESS_DB;
               end else begin
                  col_d = col_rot;
               end
            end else begin
               dwell_d = dwell_inc;
            end
         end

         PRESS_DB: begin
            if (rs_q == row_q) begin
               db_d = db_inc;
               if (db_inc == DB_DONE) begin
                  keycode_d   = key_map(col_q, row_q);
                  key_valid_d = 1'b1;
                  key_held_d  = 1'b1;
                  state_d     = HOLD;
               end
            end else begin
               // Bounce or a second row lit: abandon this column and move on.
               col_d   = col_rot;
               dwell_d = '0;
               state_d = SCAN;
            end
         end

         HOLD: begin
            key_held_d = 1'b1;
            if (rs_q == 4'b0000) begin
               db_d    = '0;
               state_d = RELEASE_DB;
            end
         end

         RELEASE_DB: begin
            if (rs_q == 4'b0000) begin
               db_d = db_inc;
               if (db_inc == DB_DONE) begin
                  key_held_d = 1'b0;
                  col_d      = col_rot;
                  dwell_d    = '0;
                  state_d    = SCAN;
               end
            end else begin
               db_d = '0;
            end
         end

         default: begin
            state_d = SCAN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SCAN;
         dwell_q     <= '0;
         db_q        <= '0;
         col_q       <= 4'b0001;
         row_q       <= 4'b0000;
         keycode_q   <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         rs_meta_q   <= 4'b0000;
         rs_q        <= 4'b0000;
      end else begin
         state_q     <= state_d;
         dwell_q     <= dwell_d;
         db_q        <= db_d;
         col_q       <= col_d;
         row_q       <= row_d;
         keycode_q   <= keycode_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
         rs_meta_q   <= rs_meta_d;
         rs_q        <= rs_d;
      end
   end

   assign kp.columns   = col_q;
   assign kp.keycode   = keycode_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_held  = key_held_q;

endmodule
